// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer driving one external combinational full adder, LSB first.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic         sub,
`endif
   output logic         ready,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         fa_a,
   output logic         fa_b,
   output logic         fa_cin,
   input  logic         fa_s,
   input  logic         fa_cout
);

   // state | meaning
   // IDLE  | waiting for start, ready=1, sum/cout hold last result
   // RUN   | one operand bit per clock through the external adder
   // DONE  | one-cycle done pulse, then back to IDLE
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam int CW = $clog2(W + 1);

   state_t         state_q, state_d;
   logic [W-1:0]   a_sr_q, a_sr_d;
   logic [W-1:0]   b_sr_q, b_sr_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           carry_q, carry_d;
   logic           cout_q, cout_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   sum_shift;
   logic [W-1:0]   b_load;
   logic           carry_load;
   logic           last_bit;

   generate
      if (W == 1) begin : g_w1
         assign sum_shift = fa_s;
      end else begin : g_wn
         assign sum_shift = {fa_s, sum_q[W-1:1]};
      end
   endgenerate

   // Subtract is a + ~b + 1, so cin is ignored when sub is set.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   assign last_bit = (cnt_q == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b_load;
               carry_d = carry_load;
               cnt_d   = CW'(W);
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = sum_shift;
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = fa_cout;
            cnt_d   = cnt_q - CW'(1);
            if (last_bit) begin
               cout_d  = fa_cout;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready  = 1'b0;
      done   = 1'b0;
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
      case (state_q)
         IDLE: ready = 1'b1;
         RUN: begin
            fa_a   = a_sr_q[0];
            fa_b   = b_sr_q[0];
            fa_cin = carry_q;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial sequencer that time-shares one external single-bit NAND full adder to add two W-bit operands, one bit per clock, LSB first. It captures operands on a start handshake and drives the full adder's a/b/cin inputs each cycle. It folds the adder's s/cout back into a sum shift register and a carry flop, then flags completion. It sits between a requester and one full_adder_nand instance; the adder stays purely combinational.

Parameters:
W, 8, operand/sum width in bits; legal range W >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only while ready=1
a  input  W  operand A, captured on accepted start
b  input  W  operand B, captured on accepted start
cin  input  1  initial carry, captured on accepted start
ready  output  1  high in IDLE; start accepted when start&ready
done  output  1  one-cycle pulse when sum/cout are valid
sum  output  W  result; held stable from done until next accepted start
cout  output  1  final carry-out; held with sum
fa_a  output  1  to full adder a
fa_b  output  1  to full adder b
fa_cin  output  1  to full adder cin
fa_s  input  1  from full adder s
fa_cout  input  1  from full adder cout

Behaviour:
- Reset is synchronous. State goes to IDLE. ready=1, done=0, sum=0, cout=0. Carry flop, operand shift regs and bit counter clear. fa_a/fa_b/fa_cin=0.
- State IDLE: ready=1. On edge with start=1, load a_sr<=a, b_sr<=b, carry<=cin, cnt<=W, sum/cout retain old values, and go to RUN.
- State RUN: ready=0. Combinationally fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry; fa_* are 0 outside RUN.
- Each RUN edge: sum <= {fa_s, sum[W-1:1]}, a_sr/b_sr shift right, carry<=fa_cout, cnt<=cnt-1. When cnt==1 at that edge, also cout<=fa_cout and go to DONE.
- State DONE: done=1 for exactly one cycle, ready=0. Next edge goes to IDLE unconditionally.
- Latency: start accepted at edge E0. Exactly W RUN edges (E1..EW). done is high in the cycle after EW. Back-to-back throughput is one operation per W+2 cycles.
- start while ready=0 (RUN or DONE) is ignored; no queuing.
- a/b/cin changing after acceptance has no effect.
- sum is partially shifted during RUN and is valid only when done=1 and thereafter until the next acceptance.
- Carry width: a single flop. Counter width: clog2(W+1) bits, no wrap. W=1 works: one RUN edge, then DONE.
- Reset asserted in any state, including mid-RUN, aborts the operation. The next cycle shows IDLE values with no done pulse.
- reset and start in the same cycle: reset wins.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), captured on accepted start.
  - sub=1: b_sr loads ~b and carry loads 1 (cin ignored), so the result is a-b in two's complement. cout=1 means no borrow.
  - sub=0: behaviour is identical to the base add.
- Undefined: port absent; add only.

Test Plan:
- W=8, a=0x5A, b=0x3C, cin=0, start one cycle -> done pulses 9 edges after acceptance (cycle after E8), sum=0x96, cout=0, ready returns 1 the following cycle.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start held high continuously with a=0x01, b=0x02 -> exactly one op per 10 cycles. Each done shows sum=0x03; mid-RUN operand changes (a=0xAA) do not alter the in-flight result.
- Reset asserted after 3 RUN edges of 0x5A+0x3C -> next cycle ready=1, done=0, sum=0, cout=0, fa_*=0. A fresh 0x10+0x20 then yields sum=0x30.
- W=1 instance: a=1, b=1, cin=1 -> done 1 edge after E1 with sum=1, cout=1.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1.
  - sub=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.
